memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 161 ++++++++++++++++
 tb/tb_memory_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Two-requester memory arbiter with round-robin tie-break and a per-transfer
// timeout. A granted requester's fields are captured onto the memory bus and
// held until the bus reports data_ready or the timeout expires. After every
// transfer the bus sees bus_enable low for at least one cycle before the next
// grant.
module memory_arbiter #(
   parameter int TIMEOUT = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic [15:0] m0_address,
   input  logic [31:0] m0_data_in,
   input  logic [3:0]  m0_write_mask,
   input  logic        m0_write_enable,
   output logic [31:0] m0_data_read,
   output logic        m0_ack,
   output logic        m0_error,
   input  logic        m1_req,
   input  logic [15:0] m1_address,
   input  logic [31:0] m1_data_in,
   input  logic [3:0]  m1_write_mask,
   input  logic        m1_write_enable,
   output logic [31:0] m1_data_read,
   output logic        m1_ack,
   output logic        m1_error,
   output logic [1:0]  grant,
   output logic [15:0] address,
   output logic [31:0] data_in,
   output logic [3:0]  write_mask,
   output logic        write_enable,
   output logic        bus_enable,
   input  logic [31:0] data_read,
   input  logic        data_ready
);

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

   // Counter value on which a transfer still lacking data_ready is aborted.
   localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [7:0]  count, count_nxt;
   logic        last_grant, last_grant_nxt;
   logic        winner;
   logic [1:0]  grant_nxt;
   logic [15:0] address_nxt;
   logic [31:0] data_in_nxt;
   logic [3:0]  write_mask_nxt;
   logic        write_enable_nxt;
   logic        bus_enable_nxt;
   logic [1:0]  ack_nxt, error_nxt;
   logic [31:0] data_read0_nxt, data_read1_nxt;

   // Next-state and next-output logic: every register holds unless a state
   // explicitly changes it; ack/error default low so they only pulse.
   always_comb begin
      state_nxt        = state;
      count_nxt        = count;
      last_grant_nxt   = last_grant;
      winner           = 1'b0;
      grant_nxt        = grant;
      address_nxt      = address;
      data_in_nxt      = data_in;
      write_mask_nxt   = write_mask;
      write_enable_nxt = write_enable;
      bus_enable_nxt   = bus_enable;
      ack_nxt          = 2'b00;
      error_nxt        = 2'b00;
      data_read0_nxt   = m0_data_read;
      data_read1_nxt   = m1_data_read;

      unique case (state)
         IDLE: begin
            if (m0_req || m1_req) begin
               // On a tie the requester not served last wins; otherwise the lone requester.
               winner           = (m0_req && m1_req) ? ~last_grant : m1_req;
               last_grant_nxt   = winner;
               grant_nxt        = winner ? 2'b10 : 2'b01;
               address_nxt      = winner ? m1_address      : m0_address;
               data_in_nxt      = winner ? m1_data_in      : m0_data_in;
               write_mask_nxt   = winner ? m1_write_mask   : m0_write_mask;
               write_enable_nxt = winner ? m1_write_enable : m0_write_enable;
               bus_enable_nxt   = 1'b1;
               count_nxt        = 8'd0;
               state_nxt        = BUSY;
            end
         end

         BUSY: begin
            if (data_ready) begin
               // Completion wins over a coincident timeout.
               bus_enable_nxt    = 1'b0;
               ack_nxt[grant[1]] = 1'b1;
               if (!write_enable) begin
                  if (grant[1]) data_read1_nxt = data_read;
                  else          data_read0_nxt = data_read;
               end
               grant_nxt = 2'b00;
               state_nxt = RELEASE;
            end else if (count == LAST_COUNT) begin
               bus_enable_nxt      = 1'b0;
               ack_nxt[grant[1]]   = 1'b1;
               error_nxt[grant[1]] = 1'b1;
               grant_nxt           = 2'b00;
               state_nxt           = RELEASE;
            end else if (count != 8'hFF) begin
               count_nxt = count + 8'd1;
            end
         end

         RELEASE: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt      = IDLE;
            bus_enable_nxt = 1'b0;
            grant_nxt      = 2'b00;
         end
      endcase
   end

   // State and output registers; reset discards any transfer in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         count        <= 8'd0;
         last_grant   <= 1'b1;
         grant        <= 2'b00;
         address      <= 16'h0000;
         data_in      <= 32'h0000_0000;
         write_mask   <= 4'hF;
         write_enable <= 1'b0;
         bus_enable   <= 1'b0;
         m0_ack       <= 1'b0;
         m1_ack       <= 1'b0;
         m0_error     <= 1'b0;
         m1_error     <= 1'b0;
         m0_data_read <= 32'h0000_0000;
         m1_data_read <= 32'h0000_0000;
      end else begin
         state        <= state_nxt;
         count        <= count_nxt;
         last_grant   <= last_grant_nxt;
         grant        <= grant_nxt;
         address      <= address_nxt;
         data_in      <= data_in_nxt;
         write_mask   <= write_mask_nxt;
         write_enable <= write_enable_nxt;
         bus_enable   <= bus_enable_nxt;
         m0_ack       <= ack_nxt[0];
         m1_ack       <= ack_nxt[1];
         m0_error     <= error_nxt[0];
         m1_error     <= error_nxt[1];
         m0_data_read <= data_read0_nxt;
         m1_data_read <= data_read1_nxt;
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized
// rounds, checked against a transaction-level model (round-robin winner,
// bus_enable length = min(delay, TIMEOUT), error iff delay > TIMEOUT).
module tb_memory_arbiter;

   localparam int TMAIN  = 32;
   localparam int TSHORT = 4;

   logic        clk, reset;
   logic        m0_req, m1_req;
   logic [15:0] m0_address, m1_address;
   logic [31:0] m0_data_in, m1_data_in;
   logic [3:0]  m0_write_mask, m1_write_mask;
   logic        m0_write_enable, m1_write_enable;
   logic [31:0] m0_data_read, m1_data_read;
   logic        m0_ack, m1_ack, m0_error, m1_error;
   logic [1:0]  grant;
   logic [15:0] address;
   logic [31:0] data_in;
   logic [3:0]  write_mask;
   logic        write_enable, bus_enable;
   logic [31:0] bus_rdata;
   logic        data_ready;

   logic        t_m0_req;
   logic [31:0] t_m0_data_read, t_m1_data_read;
   logic        t_m0_ack, t_m1_ack, t_m0_error, t_m1_error;
   logic [1:0]  t_grant;
   logic [15:0] t_address;
   logic [31:0] t_data_in;
   logic [3:0]  t_write_mask;
   logic        t_write_enable, t_bus_enable;

   int compared   = 0;
   int mismatched = 0;
   int bus_delay  = 1;
   int be_cnt     = 0;

   int          model_last;
   logic [31:0] exp_dr [2];
   logic [15:0] f_addr [2];
   logic [31:0] f_data [2];
   logic [3:0]  f_mask [2];
   logic        f_we   [2];

   memory_arbiter #(.TIMEOUT(TMAIN)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_address(m0_address), .m0_data_in(m0_data_in),
      .m0_write_mask(m0_write_mask), .m0_write_enable(m0_write_enable),
      .m0_data_read(m0_data_read), .m0_ack(m0_ack), .m0_error(m0_error),
      .m1_req(m1_req), .m1_address(m1_address), .m1_data_in(m1_data_in),
      .m1_write_mask(m1_write_mask), .m1_write_enable(m1_write_enable),
      .m1_data_read(m1_data_read), .m1_ack(m1_ack), .m1_error(m1_error),
      .grant(grant), .address(address), .data_in(data_in), .write_mask(write_mask),
      .write_enable(write_enable), .bus_enable(bus_enable),
      .data_read(bus_rdata), .data_ready(data_ready)
   );

   memory_arbiter #(.TIMEOUT(TSHORT)) dut_t4 (
      .clk(clk), .reset(reset),
      .m0_req(t_m0_req), .m0_address(16'h1234), .m0_data_in(32'h0),
      .m0_write_mask(4'h0), .m0_write_enable(1'b0),
      .m0_data_read(t_m0_data_read), .m0_ack(t_m0_ack), .m0_error(t_m0_error),
      .m1_req(1'b0), .m1_address(16'h0), .m1_data_in(32'h0),
      .m1_write_mask(4'h0), .m1_write_enable(1'b0),
      .m1_data_read(t_m1_data_read), .m1_ack(t_m1_ack), .m1_error(t_m1_error),
      .grant(t_grant), .address(t_address), .data_in(t_data_in), .write_mask(t_write_mask),
      .write_enable(t_write_enable), .bus_enable(t_bus_enable),
      .data_read(32'hFFFF_FFFF), .data_ready(1'b0)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Bus responder: raises data_ready so it is sampled on the bus_delay-th
   // rising edge after bus_enable goes high.
   always @(negedge clk) begin
      if (bus_enable) begin
         be_cnt++;
         data_ready = (be_cnt == bus_delay);
      end else begin
         be_cnt     = 0;
         data_ready = 1'b0;
      end
   end

   // Invariants: never two acks at once, error only alongside ack.
   always @(negedge clk) begin
      if (!reset) begin
         compared++;
         if ((m0_ack && m1_ack) || (m0_error && !m0_ack) || (m1_error && !m1_ack) ||
             (t_m0_error && !t_m0_ack) || t_m1_ack || t_m1_error) begin
            mismatched++;
            $display("[TB] FAIL ack_invariant: got ack=%b%b err=%b%b t_ack=%b%b t_err=%b%b, want exclusive acks and err only with ack",
                     m1_ack, m0_ack, m1_error, m0_error, t_m1_ack, t_m0_ack, t_m1_error, t_m0_error);
         end
      end
   end

   task automatic drive_fields();
      m0_address = f_addr[0]; m0_data_in = f_data[0]; m0_write_mask = f_mask[0]; m0_write_enable = f_we[0];
      m1_address = f_addr[1]; m1_data_in = f_data[1]; m1_write_mask = f_mask[1]; m1_write_enable = f_we[1];
   endtask

   // Runs one round of n_xfers transfers with the given requesters raised
   // together; hold keeps both requests up after their acks, drop_early
   // releases the owner's request in the middle of its BUSY period.
   task automatic do_round(input bit r0, input bit r1, input bit hold, input int n_xfers,
                           input int dly, input bit drop_early);
      int  done = 0, cyc = 0, gap = 0, be_len = 0, owner = -1, exp_len;
      bit  in_xfer = 0, first = 1, exp_err, got_err;
      bus_delay = dly;
      exp_len   = (dly < TMAIN) ? dly : TMAIN;
      exp_err   = (dly > TMAIN);
      drive_fields();
      m0_req = r0;
      m1_req = r1;
      while (done < n_xfers && cyc < 600) begin
         @(posedge clk); #1;
         cyc++; gap++;
         if (bus_enable && !in_xfer) begin
            in_xfer = 1; be_len = 0;
            if (m0_req && m1_req) owner = (model_last == 0) ? 1 : 0;
            else                  owner = m1_req ? 1 : 0;
            model_last = owner;
            compared++;
            if (gap !== (first ? 1 : 2)) begin
               mismatched++;
               $display("[TB] FAIL grant_latency: got %0d cycles want %0d", gap, first ? 1 : 2);
            end
            first = 0;
            compared++;
            if (grant !== ((owner == 1) ? 2'b10 : 2'b01)) begin
               mismatched++;
               $display("[TB] FAIL grant_owner: got %b want owner m%0d", grant, owner);
            end
         end
         if (bus_enable && in_xfer) begin
            be_len++;
            compared++;
            if ({address, data_in, write_mask, write_enable} !==
                {f_addr[owner], f_data[owner], f_mask[owner], f_we[owner]}) begin
               mismatched++;
               $display("[TB] FAIL bus_fields: got %h/%h/%b/%b want %h/%h/%b/%b", address, data_in,
                        write_mask, write_enable, f_addr[owner], f_data[owner], f_mask[owner], f_we[owner]);
            end
            if (drop_early && be_len == 2) begin
               if (owner == 1) m1_req = 1'b0;
               else            m0_req = 1'b0;
            end
         end
         if (m0_ack || m1_ack) begin
            done++; gap = 0;
            if (!in_xfer) begin
               compared++; mismatched++;
               $display("[TB] FAIL ack_unexpected: got ack=%b%b with no transfer, want none", m1_ack, m0_ack);
            end else begin
               in_xfer = 0;
               compared++;
               if ({m1_ack, m0_ack} !== ((owner == 1) ? 2'b10 : 2'b01)) begin
                  mismatched++;
                  $display("[TB] FAIL ack_owner: got %b%b want owner m%0d", m1_ack, m0_ack, owner);
               end
               got_err = (owner == 1) ? m1_error : m0_error;
               compared++;
               if (got_err !== exp_err) begin
                  mismatched++;
                  $display("[TB] FAIL error_flag: got %b want %b (delay %0d)", got_err, exp_err, dly);
               end
               if (!exp_err && !f_we[owner]) exp_dr[owner] = bus_rdata;
               compared++;
               if (m0_data_read !== exp_dr[0] || m1_data_read !== exp_dr[1]) begin
                  mismatched++;
                  $display("[TB] FAIL data_read: got %h/%h want %h/%h", m0_data_read, m1_data_read, exp_dr[0], exp_dr[1]);
               end
               compared++;
               if (be_len !== exp_len) begin
                  mismatched++;
                  $display("[TB] FAIL enable_length: got %0d want %0d", be_len, exp_len);
               end
               compared++;
               if (bus_enable !== 1'b0 || grant !== 2'b00) begin
                  mismatched++;
                  $display("[TB] FAIL release_state: got en=%b grant=%b want 0/00", bus_enable, grant);
               end
               if (!hold) begin
                  if (owner == 1) m1_req = 1'b0;
                  else            m0_req = 1'b0;
               end
            end
            bus_rdata = $urandom;
         end
      end
      if (done < n_xfers) begin
         compared++; mismatched++;
         $display("[TB] FAIL round_timeout: got %0d acks want %0d", done, n_xfers);
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #2 reset = 1'b1;
      #1;
      compared++;
      if ({bus_enable, grant, m0_ack, m1_ack, m0_error, m1_error, write_enable} !== 7'b0 ||
          address !== 16'h0 || data_in !== 32'h0 || write_mask !== 4'hF ||
          m0_data_read !== 32'h0 || m1_data_read !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_values: got en=%b grant=%b addr=%h din=%h mask=%h we=%b dr=%h/%h want all 0, mask F",
                  bus_enable, grant, address, data_in, write_mask, write_enable, m0_data_read, m1_data_read);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      model_last = 1;
      exp_dr[0] = 32'h0;
      exp_dr[1] = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      compared++;
      if (bus_enable !== 1'b0 || grant !== 2'b00 || t_bus_enable !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL idle_after_reset: got en=%b grant=%b t_en=%b want 0/00/0", bus_enable, grant, t_bus_enable);
      end
   endtask

   task automatic test_round_robin();
      f_addr[0] = 16'h0100; f_data[0] = 32'hA0A0_A0A0; f_mask[0] = 4'h0; f_we[0] = 1'b0;
      f_addr[1] = 16'h8200; f_data[1] = 32'hB1B1_B1B1; f_mask[1] = 4'h3; f_we[1] = 1'b0;
      bus_rdata = 32'h1111_2222;
      do_round(1'b1, 1'b1, 1'b1, 4, 3, 1'b0);
   endtask

   task automatic test_read();
      f_addr[0] = 16'h4008; f_data[0] = 32'h0; f_mask[0] = 4'hF; f_we[0] = 1'b0;
      bus_rdata = 32'hDEAD_BEEF;
      do_round(1'b1, 1'b0, 1'b0, 1, 8, 1'b0);
      compared++;
      if (m0_data_read !== 32'hDEAD_BEEF || bus_enable !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL read_deadbeef: got %h en=%b want deadbeef en=0", m0_data_read, bus_enable);
      end
   endtask

   task automatic test_write();
      f_addr[1] = 16'hC010; f_data[1] = 32'h1234_5678; f_mask[1] = 4'b1100; f_we[1] = 1'b1;
      do_round(1'b0, 1'b1, 1'b0, 1, 5, 1'b1);
   endtask

   task automatic test_boundaries();
      do_round(1'b1, 1'b0, 1'b0, 1, TMAIN, 1'b0);
      do_round(1'b0, 1'b1, 1'b0, 1, TMAIN + 1, 1'b0);
      do_round(1'b1, 1'b1, 1'b0, 2, 1, 1'b0);
   endtask

   task automatic test_timeout();
      int cyc = 0, len = 0;
      bit seen = 0;
      t_m0_req = 1'b1;
      while (!seen && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
         if (t_bus_enable) len++;
         if (t_m0_ack) begin
            seen = 1;
            t_m0_req = 1'b0;
            compared++;
            if (t_m0_error !== 1'b1 || len !== TSHORT || t_m0_data_read !== 32'h0 || t_bus_enable !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL timeout_abort: got err=%b len=%0d dr=%h en=%b want 1/%0d/0/0",
                        t_m0_error, len, t_m0_data_read, t_bus_enable, TSHORT);
            end
         end
      end
      if (!seen) begin
         compared++; mismatched++;
         $display("[TB] FAIL timeout_no_ack: got no ack in %0d cycles want ack after %0d", cyc, TSHORT);
      end
      @(posedge clk); #1;
      compared++;
      if ({t_m0_ack, t_m0_error, t_bus_enable, t_grant} !== 5'b0) begin
         mismatched++;
         $display("[TB] FAIL timeout_idle: got ack=%b err=%b en=%b grant=%b want all 0",
                  t_m0_ack, t_m0_error, t_bus_enable, t_grant);
      end
   endtask

   task automatic test_reset_busy();
      int cyc = 0;
      bit stray = 0;
      f_addr[0] = 16'h2468; f_data[0] = 32'h0; f_mask[0] = 4'h0; f_we[0] = 1'b0;
      drive_fields();
      bus_delay = 20;
      m0_req = 1'b1;
      while (!bus_enable && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      compared++;
      if (bus_enable !== 1'b0 || grant !== 2'b00 || m0_ack !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_in_busy: got en=%b grant=%b ack=%b want 0/00/0", bus_enable, grant, m0_ack);
      end
      m0_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      model_last = 1;
      exp_dr[0] = 32'h0;
      exp_dr[1] = 32'h0;
      repeat (4) begin
         @(posedge clk); #1;
         if (m0_ack || m1_ack || bus_enable) stray = 1;
      end
      compared++;
      if (stray) begin
         mismatched++;
         $display("[TB] FAIL reset_discard: got activity after reset want none");
      end
      bus_rdata = 32'hCAFE_F00D;
      do_round(1'b1, 1'b0, 1'b0, 1, 6, 1'b0);
   endtask

   task automatic test_random();
      bit r0, r1;
      int dly;
      for (int i = 0; i < 14; i++) begin
         for (int n = 0; n < 2; n++) begin
            f_addr[n] = 16'($urandom);
            f_data[n] = $urandom;
            f_mask[n] = 4'($urandom);
            f_we[n]   = 1'($urandom_range(0, 1));
         end
         r0 = 1'($urandom_range(0, 1));
         r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
         dly = $urandom_range(1, 40);
         bus_rdata = $urandom;
         do_round(r0, r1, 1'b0, int'(r0) + int'(r1), dly, 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      reset = 1'b0;
      m0_req = 1'b0; m1_req = 1'b0; t_m0_req = 1'b0;
      data_ready = 1'b0;
      bus_rdata = 32'h0;
      for (int n = 0; n < 2; n++) begin
         f_addr[n] = 16'h0; f_data[n] = 32'h0; f_mask[n] = 4'hF; f_we[n] = 1'b0;
         exp_dr[n] = 32'h0;
      end
      model_last = 1;
      drive_fields();
      test_reset();
      test_round_robin();
      test_read();
      test_write();
      test_boundaries();
      test_timeout();
      test_reset_busy();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
